// File: rtl/rx_sample_fifo.sv
// RX sample FIFO: buffers 64-bit samples and hands them to the CPU read side as 32-bit words.
// Define RX_SAMPLE_FIFO_PACK16_EN to return one packed {Q[15:0], I[15:0]} word per sample.
module rx_sample_fifo #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  rd_en_i,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2+1:0] words_avail_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  input  logic                  clear_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int WW    = DEPTH_LOG2 + 2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] entries_q, entries_d;
  logic [WW-1:0] words_q, words_d;
  logic          overflow_q, overflow_d;
  logic          ready_q, ready_d;
  logic          rd_valid_q;
  logic          full;
  logic          wr_fire;
  logic          pop_fire;
  logic          release_entry;

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   rd_entry_q;

  // Extra pointer bit lets entries reach DEPTH without aliasing to empty.
  assign entries_q = wr_ptr_q - rd_ptr_q;
  assign full      = (entries_q == PW'(DEPTH));
  assign wr_fire   = s_axis_tvalid_i && !full && !clear_i;
  assign pop_fire  = rd_en_i && (words_q != '0) && !clear_i;

`ifdef RX_SAMPLE_FIFO_PACK16_EN
  assign release_entry = pop_fire;
`else
  logic half_q, half_d;
  logic rd_hi_q;

  assign release_entry = pop_fire && half_q;
  assign half_d        = clear_i ? 1'b0 : (pop_fire ? ~half_q : half_q);
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_fire)               wr_ptr_d   = wr_ptr_q + 1'b1;
      if (release_entry)         rd_ptr_d   = rd_ptr_q + 1'b1;
      if (s_axis_tvalid_i && full) overflow_d = 1'b1;
    end
  end

  assign entries_d = wr_ptr_d - rd_ptr_d;
  assign ready_d   = (entries_d != PW'(DEPTH));

`ifdef RX_SAMPLE_FIFO_PACK16_EN
  assign words_d = WW'(entries_d);
`else
  // A half-consumed entry still holds one readable word.
  assign words_d = {entries_d, 1'b0} - WW'(half_d);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      words_q    <= words_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      rd_valid_q <= pop_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_axis_tdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_entry_q <= '0;
    end else if (pop_fire) begin
      rd_entry_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

`ifdef RX_SAMPLE_FIFO_PACK16_EN
  assign rd_data_o = {rd_entry_q[63:48], rd_entry_q[31:16]};
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q  <= 1'b0;
      rd_hi_q <= 1'b0;
    end else begin
      half_q <= half_d;
      if (pop_fire) rd_hi_q <= half_q;
    end
  end

  assign rd_data_o = rd_hi_q ? rd_entry_q[63:32] : rd_entry_q[31:0];
`endif

  assign s_axis_tready_o = ready_q;
  assign rd_valid_o      = rd_valid_q;
  assign words_avail_o   = words_q;
  assign empty_o         = (words_q == '0);
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Self-checking bench for rx_sample_fifo against a word-queue reference model.
// Honours RX_SAMPLE_FIFO_PACK16_EN the same way the design does.
module tb_rx_sample_fifo;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   s_axis_tdata_i;
  logic          s_axis_tvalid_i;
  logic          s_axis_tready_o;
  logic          rd_en_i;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o;
  logic [DL+1:0] words_avail_o;
  logic          empty_o;
  logic          overflow_o;
  logic          clear_i;

  always #5 clk = ~clk;

  rx_sample_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .rd_en_i         (rd_en_i),
    .rd_data_o       (rd_data_o),
    .rd_valid_o      (rd_valid_o),
    .words_avail_o   (words_avail_o),
    .empty_o         (empty_o),
    .overflow_o      (overflow_o),
    .clear_i         (clear_i)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_q[$];
  logic        m_ovf   = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic        m_ready = 1'b0;

  // Entries held: a partially read sample still occupies its slot.
  function automatic int m_entries();
`ifdef RX_SAMPLE_FIFO_PACK16_EN
    return model_q.size();
`else
    return (model_q.size() + 1) / 2;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic rd, input logic clr);
    s_axis_tvalid_i = v;
    s_axis_tdata_i  = d;
    rd_en_i         = rd;
    clear_i         = clr;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      m_ovf = 1'b0; m_valid = 1'b0; m_data = '0; m_ready = 1'b0;
    end else if (clr) begin
      model_q.delete();
      m_ovf = 1'b0; m_valid = 1'b0; m_ready = 1'b1;
    end else begin
      bit was_full;
      was_full = (m_entries() == DEPTH);
      m_valid  = 1'b0;
      if (rd && model_q.size() != 0) begin
        m_data  = model_q.pop_front();
        m_valid = 1'b1;
      end
      if (v) begin
        if (was_full) m_ovf = 1'b1;
        else begin
`ifdef RX_SAMPLE_FIFO_PACK16_EN
          model_q.push_back({d[63:48], d[31:16]});
`else
          model_q.push_back(d[31:0]);
          model_q.push_back(d[63:32]);
`endif
        end
      end
      m_ready = (m_entries() != DEPTH);
    end
    #1;
    check("rd_valid", 32'(rd_valid_o), 32'(m_valid));
    check("rd_data", rd_data_o, m_data);
    check("words_avail", 32'(words_avail_o), 32'(model_q.size()));
    check("empty", 32'(empty_o), 32'(model_q.size() == 0));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("tready", 32'(s_axis_tready_o), 32'(m_ready));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0;
    s_axis_tvalid_i = 1'b0; s_axis_tdata_i = '0; rd_en_i = 1'b0; clear_i = 1'b0;

    // Reset, then idle: ready rises on the first cycle out of reset
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    check("ready_after_reset", 32'(s_axis_tready_o), 32'd1);
    step(0, 0, 0, 0);

    // Single sample, two pops (one packed pop in PACK16 builds)
`ifdef RX_SAMPLE_FIFO_PACK16_EN
    step(1, 64'hAAAA_0000_BBBB_0000, 0, 0);
    check("pack_avail", 32'(words_avail_o), 32'd1);
    step(0, 0, 1, 0);
    check("pack_word", rd_data_o, 32'hAAAA_BBBB);
`else
    step(1, 64'h1111_0000_2222_0000, 0, 0);
    check("avail_two", 32'(words_avail_o), 32'd2);
    step(0, 0, 1, 0);
    check("low_word", rd_data_o, 32'h2222_0000);
    step(0, 0, 1, 0);
    check("high_word", rd_data_o, 32'h1111_0000);
`endif
    step(0, 0, 0, 0);

    // Fill to capacity, one dropped sample, then drain everything
    for (int i = 0; i < DEPTH; i++) step(1, rnd64(), 0, 0);
    check("full_ready_low", 32'(s_axis_tready_o), 32'd0);
    step(1, rnd64(), 0, 0);
    check("overflow_set", 32'(overflow_o), 32'd1);
    step(1, rnd64(), 1, 0);
    while (model_q.size() != 0) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("overflow_sticky", 32'(overflow_o), 32'd1);

    // Clear beats a concurrent write and pop
    for (int i = 0; i < 5; i++) step(1, rnd64(), 0, 0);
    step(0, 0, 1, 0);
    step(1, rnd64(), 1, 1);
    check("clear_avail", 32'(words_avail_o), 32'd0);
    step(0, 0, 1, 0);
    check("pop_empty_valid", 32'(rd_valid_o), 32'd0);

    // Write every 4 cycles, pop every 2, with coincident write+pop
    for (int i = 0; i < 128; i++) step(i % 4 == 0, rnd64(), i % 2 == 0, 0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, rnd64(), $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);

    // Reset mid-operation discards contents
    for (int i = 0; i < 6; i++) step(1, rnd64(), 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    step(1, rnd64(), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_sample_fifo.md
Name: rx_sample_fifo

Overview:
- Downstream consumer of the RX chain's 64-bit sample stream (format {Q[15:0],16'd0,I[15:0],16'd0} or full-precision 64-bit).
- Buffers samples in an on-chip FIFO and presents them to the CPU register-read side as 32-bit words, one pop per read strobe.
- Tracks occupancy, drops samples when full and flags overflow, and supports a software flush.

Parameters:
DEPTH_LOG2, 10, log2 of FIFO depth in 64-bit entries (default 1024 entries).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
s_axis_tdata_i  in  64  RX sample from RX chain
s_axis_tvalid_i  in  1  sample valid, single-cycle pulse per sample
s_axis_tready_o  out  1  high when FIFO can accept a sample
rd_en_i  in  1  pop one 32-bit word (bus read strobe)
rd_data_o  out  32  popped word
rd_valid_o  out  1  rd_data_o updated this cycle
words_avail_o  out  DEPTH_LOG2+2  32-bit words currently readable
empty_o  out  1  words_avail_o == 0
overflow_o  out  1  sticky: at least one sample dropped since last clear/reset
clear_i  in  1  flush FIFO and clear overflow

Behaviour:
- Reset (rst_n low at posedge clk): write/read pointers, half-word select, rd_data_o, rd_valid_o, words_avail_o, overflow_o = 0; empty_o = 1; s_axis_tready_o = 0 during reset, 1 from the first cycle after rst_n returns high. Reset mid-operation discards all contents.
- Storage: 2**DEPTH_LOG2 entries x 64 bits, inferred RAM. Entry count range 0..2**DEPTH_LOG2 (extra pointer bit distinguishes full from empty).
- Write: if s_axis_tvalid_i && !full, store tdata at write pointer, advance pointer, entry count +1. s_axis_tready_o = !full, registered.
- Full drop: s_axis_tvalid_i while full -> sample discarded, overflow_o set the next cycle, sticky. Upstream does not stall, so ready is advisory only.
- Read word order per entry: low word tdata[31:0] first, then high word tdata[63:32]. A half-select bit toggles on each pop. The entry is released (read pointer +1) only after its high word is popped.
- Pop: rd_en_i && words_avail_o != 0 -> rd_data_o loaded and rd_valid_o = 1 on the next cycle (latency 1). rd_valid_o is otherwise 0. rd_data_o holds its last value.
- Pop when empty: ignored. No pointer change, rd_valid_o stays 0, no error flag.
- words_avail_o = 2*entries - half_select, registered, updated the same cycle as the pointers. empty_o derives from the same register.
- Simultaneous write and pop: both take effect. Entry count is unchanged if the pop completes an entry, and words_avail_o changes by +2-1 = +1 net otherwise. Write while full with a completing pop in the same cycle still counts as full: sample dropped.
- clear_i: highest priority over write and pop in the same cycle. Pointers, half-select and overflow are zeroed; the concurrent sample is discarded without setting overflow. rd_valid_o = 0 the next cycle.

Optional Feature:
Macro RX_SAMPLE_FIFO_PACK16_EN.
- Defined: each entry yields a single 32-bit word {tdata[63:48], tdata[31:16]} (Q high half, I low half). The half-select logic is removed, words_avail_o = entries, and every pop releases one entry.
- Undefined: two words per entry as described above.

Test Plan:
- Reset then idle -> empty_o=1, words_avail_o=0, s_axis_tready_o=1 one cycle after rst_n high, overflow_o=0.
- Write sample 64'h1111_0000_2222_0000, pop twice -> rd_data_o 32'h2222_0000 then 32'h1111_0000, each with rd_valid_o one cycle after rd_en_i; words_avail_o 2->1->0.
- Write 2**DEPTH_LOG2 samples, one more write -> s_axis_tready_o=0, extra sample dropped, overflow_o=1. Drain all 2*2**DEPTH_LOG2 words -> data matches first 1024 samples in order, overflow_o still 1.
- Continuous write every 4 cycles with pop every 2 cycles, including same-cycle write+pop -> no loss, words_avail_o never negative, data order preserved.
- Fill 5 samples, assert clear_i together with tvalid and rd_en -> next cycle words_avail_o=0, overflow_o=0, rd_valid_o=0; a pop on empty -> rd_valid_o stays 0.
- With RX_SAMPLE_FIFO_PACK16_EN: write 64'hAAAA_0000_BBBB_0000, pop -> rd_data_o 32'hAAAA_BBBB, words_avail_o 1->0.
